// File: rtl/mips_mem_pkg.sv
// Shared sizing and entry type for the store buffer between EX/MEM and datamem.
package mips_mem_pkg;

   localparam int SB_DEPTH = 4;
   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular store queue: push at tail, pop at head, and a youngest-first view of
// every entry (index 0 = most recently pushed) for the load forwarding comparator.
module sb_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic [AW-1:0]             push_addr,
   input  logic [DW-1:0]             push_data,
   input  logic                      pop,
   output logic                      full,
   output logic                      empty,
   output logic [AW-1:0]             head_addr,
   output logic [DW-1:0]             head_data,
   output logic [DEPTH-1:0]          yng_vld,
   output logic [DEPTH-1:0][AW-1:0]  yng_addr,
   output logic [DEPTH-1:0][DW-1:0]  yng_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [AW-1:0] addr_mem [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   // Entry storage carries no reset; validity is derived from count alone.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[tail] <= push_addr;
         data_mem[tail] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign head_addr = addr_mem[head];
   assign head_data = data_mem[head];

   always_comb begin
      yng_vld  = '0;
      yng_addr = '0;
      yng_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         yng_vld[k]  = (CW'(k) < count);
         yng_addr[k] = addr_mem[tail - PW'(k + 1)];
         yng_data[k] = data_mem[tail - PW'(k + 1)];
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Store buffer in front of single-port datamem: loads win the port, stores drain in
// idle cycles, and loads hitting a pending store are forwarded (youngest match).
module store_buffer
   import mips_mem_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = ADDR_W,
   parameter int DW    = DATA_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          st_valid,
   input  logic [AW-1:0] st_addr,
   input  logic [DW-1:0] st_data,
   output logic          st_stall,
   input  logic          ld_req,
   input  logic [AW-1:0] ld_addr,
   output logic          ld_stall,
   output logic [DW-1:0] ld_rdata,
   output logic          sb_empty,
   output logic          MemWrite,
   output logic          MemRead,
   output logic [AW-1:0] Addr,
   output logic [DW-1:0] Wdata,
   input  logic [DW-1:0] Rdata
);

   logic                     full;
   logic                     empty;
   logic [AW-1:0]            head_addr;
   logic [DW-1:0]            head_data;
   logic [DEPTH-1:0]         yng_vld;
   logic [DEPTH-1:0][AW-1:0] yng_addr;
   logic [DEPTH-1:0][DW-1:0] yng_data;

   logic          push;
   logic          drain;
   logic          rd;
   logic          ld_acc;
   logic          hit;
   logic [DW-1:0] hit_data;
   logic          fwd_q;
   logic [DW-1:0] fwd_data_q;

   assign push = st_valid && !full;

   sb_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_addr (st_addr),
      .push_data (st_data),
      .pop       (drain),
      .full      (full),
      .empty     (empty),
      .head_addr (head_addr),
      .head_data (head_data),
      .yng_vld   (yng_vld),
      .yng_addr  (yng_addr),
      .yng_data  (yng_data)
   );

   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (yng_vld[k] && (yng_addr[k] == ld_addr)) begin
            hit      = 1'b1;
            hit_data = yng_data[k];
         end
      end
   end

   always_comb begin
      drain  = 1'b0;
      rd     = 1'b0;
      ld_acc = 1'b0;
      if (ld_req && full) begin
         drain = 1'b1;
      end else if (ld_req) begin
         ld_acc = 1'b1;
         if (hit) drain = !empty;
         else     rd    = 1'b1;
      end else begin
         drain = !empty;
      end
      // Discarded stores must never reach datamem, even in the reset cycle itself.
      if (reset) begin
         drain  = 1'b0;
         rd     = 1'b0;
         ld_acc = 1'b0;
      end
   end

   assign MemWrite = drain;
   assign MemRead  = rd;
   assign Addr     = drain ? head_addr : (rd ? ld_addr : '0);
   assign Wdata    = drain ? head_data : '0;
   assign st_stall = full;
   assign ld_stall = ld_req && full;
   assign sb_empty = empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         fwd_q      <= 1'b0;
         fwd_data_q <= '0;
      end else if (ld_acc) begin
         fwd_q      <= hit;
         fwd_data_q <= hit_data;
      end
   end

   assign ld_rdata = fwd_q ? fwd_data_q : Rdata;

endmodule

// File: tb/tb_store_buffer.sv
// Store buffer bench: directed vector table, wrap/reset sequences, and randomized
// traffic checked against a queue-plus-architectural-memory reference model.
module tb_store_buffer;
   import mips_mem_pkg::*;

   localparam int DEPTH = SB_DEPTH;

   logic        clk;
   logic        reset;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_stall;
   logic        ld_req;
   logic [31:0] ld_addr;
   logic        ld_stall;
   logic [31:0] ld_rdata;
   logic        sb_empty;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] Addr;
   logic [31:0] Wdata;
   logic [31:0] Rdata;

   store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .st_valid (st_valid),
      .st_addr  (st_addr),
      .st_data  (st_data),
      .st_stall (st_stall),
      .ld_req   (ld_req),
      .ld_addr  (ld_addr),
      .ld_stall (ld_stall),
      .ld_rdata (ld_rdata),
      .sb_empty (sb_empty),
      .MemWrite (MemWrite),
      .MemRead  (MemRead),
      .Addr     (Addr),
      .Wdata    (Wdata),
      .Rdata    (Rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] dmem [64];
   logic [31:0] arch [64];
   sb_entry_t   sbq [$];
   bit          ld_pend;
   logic [31:0] ld_exp;
   bit          st_acc;
   logic        cap_mw, cap_mr;
   logic [31:0] cap_a, cap_wd;

   typedef struct {
      logic        sv;
      logic [31:0] sa;
      logic [31:0] sd;
      logic        lr;
      logic [31:0] la;
      logic        mw;
      logic        mr;
      logic [31:0] a;
      logic [31:0] wd;
      logic        sst;
      logic        lst;
      logic        emp;
      logic        crd;
      logic [31:0] rd;
   } vec_t;
   vec_t vt [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic lr, input logic [31:0] la);
      st_valid = sv;
      st_addr  = sa;
      st_data  = sd;
      ld_req   = lr;
      ld_addr  = la;
   endtask

   task automatic add(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic lr, input logic [31:0] la,
                      input logic mw, input logic mr, input logic [31:0] a, input logic [31:0] wd,
                      input logic sst, input logic lst, input logic emp,
                      input logic crd, input logic [31:0] rd);
      vec_t v;
      v = '{sv, sa, sd, lr, la, mw, mr, a, wd, sst, lst, emp, crd, rd};
      vt.push_back(v);
   endtask

   // Reference: pending stores form a program-order queue; arch holds the
   // architecturally latest value of every word; loads see pre-store state.
   task automatic model_step();
      bit full, hit, ld_ok, exp_rd, exp_dr;
      cap_mw = MemWrite;
      cap_mr = MemRead;
      cap_a  = Addr;
      cap_wd = Wdata;
      if (reset) begin
         chk("reset_memwrite", {31'b0, MemWrite}, 32'd0);
         chk("reset_memread", {31'b0, MemRead}, 32'd0);
         sbq.delete();
         ld_pend = 0;
         st_acc  = 0;
         for (int i = 0; i < 64; i++) arch[i] = dmem[i];
         return;
      end
      full = (sbq.size() == DEPTH);
      hit  = 0;
      foreach (sbq[i]) if (sbq[i].addr == ld_addr) hit = 1;
      ld_ok  = ld_req && !full;
      exp_rd = ld_ok && !hit;
      exp_dr = (sbq.size() > 0) && !exp_rd;
      chk("model_st_stall", {31'b0, st_stall}, {31'b0, full});
      chk("model_ld_stall", {31'b0, ld_stall}, {31'b0, ld_req && full});
      chk("model_sb_empty", {31'b0, sb_empty}, {31'b0, sbq.size() == 0});
      chk("model_memread", {31'b0, MemRead}, {31'b0, exp_rd});
      chk("model_memwrite", {31'b0, MemWrite}, {31'b0, exp_dr});
      if (exp_dr) begin
         chk("model_drain_addr", Addr, sbq[0].addr);
         chk("model_drain_wdata", Wdata, sbq[0].data);
      end else if (exp_rd) begin
         chk("model_read_addr", Addr, ld_addr);
      end
      if (ld_pend) chk("model_ld_rdata", ld_rdata, ld_exp);
      if (exp_dr) void'(sbq.pop_front());
      ld_pend = ld_ok;
      if (ld_ok) ld_exp = arch[ld_addr[5:0]];
      st_acc = st_valid && !full;
      if (st_acc) begin
         sbq.push_back('{addr: st_addr, data: st_data});
         arch[st_addr[5:0]] = st_data;
      end
   endtask

   // Datamem behaviour: registered read, write at the clock edge.
   task automatic mem_step();
      if (cap_mr) Rdata = dmem[cap_a[5:0]];
      if (cap_mw) dmem[cap_a[5:0]] = cap_wd;
   endtask

   task automatic finish_cycle();
      model_step();
      @(posedge clk);
      #1;
      mem_step();
   endtask

   task automatic tick();
      @(negedge clk);
      finish_cycle();
   endtask

   task automatic drain_and_compare(input string tag);
      int n;
      n = 0;
      drive(0, 0, 0, 0, 0);
      while (sbq.size() > 0 && n < 20) begin
         tick();
         n++;
      end
      tick();
      if (sbq.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_drain_timeout: %0d stores still pending, expected 0", tag, sbq.size());
      end
      for (int i = 0; i < 64; i++) chk($sformatf("%s_dmem[%0d]", tag, i), dmem[i], arch[i]);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int tries;
      for (int i = 0; i < 64; i++) dmem[i] = 32'hD000_0000 + i;
      Rdata = '0;
      ld_pend = 0;
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      tick();
      tick();
      reset = 1'b0;

      //   sv  sa      sd       lr la     | mw mr a       wd       sst lst emp | crd rd
      add(1, 'h05, 'hAA,  0, 0,      0, 0, 0,     0,     0, 0, 1,  0, 0);
      add(0, 0,    0,     0, 0,      1, 0, 'h05,  'hAA,  0, 0, 0,  0, 0);
      add(0, 0,    0,     0, 0,      0, 0, 0,     0,     0, 0, 1,  0, 0);
      add(1, 'h07, 'h11,  1, 'h09,   0, 1, 'h09,  0,     0, 0, 1,  0, 0);
      add(1, 'h07, 'h22,  1, 'h09,   0, 1, 'h09,  0,     0, 0, 0,  1, 'hD000_0009);
      add(0, 0,    0,     1, 'h07,   1, 0, 'h07,  'h11,  0, 0, 0,  1, 'hD000_0009);
      add(0, 0,    0,     0, 0,      1, 0, 'h07,  'h22,  0, 0, 0,  1, 'h22);
      add(0, 0,    0,     0, 0,      0, 0, 0,     0,     0, 0, 1,  0, 0);
      add(1, 'h05, 'h55,  1, 'h01,   0, 1, 'h01,  0,     0, 0, 1,  0, 0);
      add(1, 'h07, 'h77,  1, 'h01,   0, 1, 'h01,  0,     0, 0, 0,  1, 'hD000_0001);
      add(0, 0,    0,     1, 'h03,   0, 1, 'h03,  0,     0, 0, 0,  1, 'hD000_0001);
      add(0, 0,    0,     0, 0,      1, 0, 'h05,  'h55,  0, 0, 0,  1, 'hD000_0003);
      add(0, 0,    0,     0, 0,      1, 0, 'h07,  'h77,  0, 0, 0,  0, 0);
      add(0, 0,    0,     0, 0,      0, 0, 0,     0,     0, 0, 1,  0, 0);
      add(1, 'h10, 'h100, 1, 'h02,   0, 1, 'h02,  0,     0, 0, 1,  0, 0);
      add(1, 'h11, 'h101, 1, 'h02,   0, 1, 'h02,  0,     0, 0, 0,  1, 'hD000_0002);
      add(1, 'h12, 'h102, 1, 'h02,   0, 1, 'h02,  0,     0, 0, 0,  1, 'hD000_0002);
      add(1, 'h13, 'h103, 1, 'h02,   0, 1, 'h02,  0,     0, 0, 0,  1, 'hD000_0002);
      add(1, 'h14, 'h104, 1, 'h02,   1, 0, 'h10,  'h100, 1, 1, 0,  1, 'hD000_0002);
      add(1, 'h14, 'h104, 1, 'h02,   0, 1, 'h02,  0,     0, 0, 0,  0, 0);
      add(0, 0,    0,     0, 0,      1, 0, 'h11,  'h101, 1, 0, 0,  1, 'hD000_0002);
      add(0, 0,    0,     0, 0,      1, 0, 'h12,  'h102, 0, 0, 0,  0, 0);
      add(0, 0,    0,     0, 0,      1, 0, 'h13,  'h103, 0, 0, 0,  0, 0);
      add(0, 0,    0,     0, 0,      1, 0, 'h14,  'h104, 0, 0, 0,  0, 0);
      add(0, 0,    0,     0, 0,      0, 0, 0,     0,     0, 0, 1,  0, 0);

      foreach (vt[i]) begin
         drive(vt[i].sv, vt[i].sa, vt[i].sd, vt[i].lr, vt[i].la);
         @(negedge clk);
         chk($sformatf("vec%0d_memwrite", i), {31'b0, MemWrite}, {31'b0, vt[i].mw});
         chk($sformatf("vec%0d_memread", i), {31'b0, MemRead}, {31'b0, vt[i].mr});
         chk($sformatf("vec%0d_addr", i), Addr, vt[i].a);
         chk($sformatf("vec%0d_wdata", i), Wdata, vt[i].wd);
         chk($sformatf("vec%0d_st_stall", i), {31'b0, st_stall}, {31'b0, vt[i].sst});
         chk($sformatf("vec%0d_ld_stall", i), {31'b0, ld_stall}, {31'b0, vt[i].lst});
         chk($sformatf("vec%0d_sb_empty", i), {31'b0, sb_empty}, {31'b0, vt[i].emp});
         if (vt[i].crd) chk($sformatf("vec%0d_ld_rdata", i), ld_rdata, vt[i].rd);
         finish_cycle();
      end
      drain_and_compare("directed");

      // Wrap-around: ten stores through a four-entry ring with loads in between.
      for (int i = 0; i < 10; i++) begin
         tries = 0;
         do begin
            drive(1, 32'(i), 32'h900 + 32'(i), 1, 32'((i * 7) % 10));
            tick();
            tries++;
         end while (!st_acc && tries < 8);
         if (!st_acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wrap_store%0d: not accepted after %0d cycles, expected acceptance", i, tries);
         end
      end
      drain_and_compare("wrap");

      // Reset mid-traffic: three stores held back by miss loads, then discarded.
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'd40 + 32'(i), 32'hE0 + 32'(i), 1, 32'd50);
         tick();
      end
      drive(0, 0, 0, 0, 0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("post_reset_sb_empty", {31'b0, sb_empty}, 32'd1);
      chk("post_reset_st_stall", {31'b0, st_stall}, 32'd0);
      for (int i = 0; i < 3; i++)
         chk($sformatf("reset_discard_dmem[%0d]", 40 + i), dmem[40 + i], 32'hD000_0028 + 32'(i));

      for (int c = 0; c < 400; c++) begin
         drive(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom,
               1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)));
         tick();
      end
      drain_and_compare("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
